// File: rtl/aw_waiver_pkg.sv
// Shared types and helpers for the assertion-waiver window generator.
package aw_waiver_pkg;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_ARMING = 3'd1,
        S_ACTIVE = 3'd2,
        S_WAIVE  = 3'd3,
        S_HOLD   = 3'd4
    } aw_win_state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int aw_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int aw_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aw_waiver_chan.sv
// One waiver channel: trigger debounce, window FSM, enable edge pulses and
// a saturating count of ACTIVE->WAIVE events.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  S_OFF    | globally disabled or never armed; waits for an arm edge
//  S_ARMING | arm edge seen, counting ARM_DLY cycles before enabling
//  S_ACTIVE | checker assertions enabled
//  S_WAIVE  | filtered trigger high, assertions waived
//  S_HOLD   | trigger fell, still waived for HOLD_CYC cycles
module aw_waiver_chan
    import aw_waiver_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int HOLD_CYC   = 8,
    parameter int ARM_DLY    = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             global_en,
    input  logic             arm,
    input  logic             trig,
    output logic             chk_en,
    output logic             on_pulse,
    output logic             off_pulse,
    output logic [CNT_W-1:0] waive_cnt
);

    localparam int STAB_W = aw_cnt_w(STABLE_CYC);
    localparam int TMR_W  = aw_cnt_w(aw_max(HOLD_CYC, ARM_DLY));

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
    // Unreachable compare values collapse to zero when a delay is disabled.
    localparam logic [TMR_W-1:0] ARM_LAST  = (ARM_DLY  > 0) ? TMR_W'(ARM_DLY - 1)  : '0;
    localparam logic [TMR_W-1:0] HOLD_LAST = (HOLD_CYC > 0) ? TMR_W'(HOLD_CYC - 1) : '0;

    aw_win_state_e     state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [STAB_W-1:0] stab_cnt;
    logic              trig_f;
    logic              arm_q;
    logic              arm_rise;
    logic              en_q;
    logic              waive_inc;

    assign arm_rise = arm & ~arm_q;

    // Arm edge register and trigger debounce: a change is accepted only after
    // it has been seen for STABLE_CYC consecutive cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arm_q    <= 1'b0;
            trig_f   <= 1'b0;
            stab_cnt <= '0;
        end else begin
            arm_q <= arm;
            if (trig != trig_f) begin
                if (stab_cnt == STAB_LAST) begin
                    trig_f   <= trig;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + STAB_W'(1);
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    // Window FSM next-state; dropping the global enable overrides everything.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        waive_inc = 1'b0;
        if (!global_en) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (arm_rise) begin
                        tmr_d = '0;
                        if (ARM_DLY == 0) begin
                            state_d = trig_f ? S_WAIVE : S_ACTIVE;
                        end else begin
                            state_d = S_ARMING;
                        end
                    end
                end
                S_ARMING: begin
                    if (tmr_q == ARM_LAST) begin
                        state_d = trig_f ? S_WAIVE : S_ACTIVE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (trig_f) begin
                        state_d   = S_WAIVE;
                        waive_inc = 1'b1;
                    end
                end
                S_WAIVE: begin
                    if (!trig_f) begin
                        tmr_d   = '0;
                        state_d = (HOLD_CYC == 0) ? S_ACTIVE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (trig_f) begin
                        state_d = S_WAIVE;
                    end else if (tmr_q == HOLD_LAST) begin
                        state_d = S_ACTIVE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // State, shared arm/hold timer, delayed enable and saturating event count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_OFF;
            tmr_q     <= '0;
            en_q      <= 1'b0;
            waive_cnt <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            en_q    <= chk_en;
            if (waive_inc && (waive_cnt != '1)) begin
                waive_cnt <= waive_cnt + CNT_W'(1);
            end
        end
    end

    assign chk_en    = (state_q == S_ACTIVE);
    assign on_pulse  = chk_en & ~en_q;
    assign off_pulse = ~chk_en & en_q;

endmodule

// File: rtl/aw_waiver_window_gen.sv
// Per-checker waiver window generator: NUM_CH independent channels turning raw
// waive conditions into qualified enables and $asserton/$assertoff pulses.
module aw_waiver_window_gen
    import aw_waiver_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int STABLE_CYC = 4,
    parameter int HOLD_CYC   = 8,
    parameter int ARM_DLY    = 3,
    parameter int CNT_W      = 8
) (
    input  logic                    I_CLK,
    input  logic                    I_RSTN,
    input  logic                    i_global_en,
    input  logic [NUM_CH-1:0]       i_arm,
    input  logic [NUM_CH-1:0]       i_trig,
    output logic [NUM_CH-1:0]       o_chk_en,
    output logic [NUM_CH-1:0]       o_on_pulse,
    output logic [NUM_CH-1:0]       o_off_pulse,
    output logic [NUM_CH*CNT_W-1:0] o_waive_cnt
);

    // One channel instance per checker; counters packed by channel index.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        aw_waiver_chan #(
            .STABLE_CYC (STABLE_CYC),
            .HOLD_CYC   (HOLD_CYC),
            .ARM_DLY    (ARM_DLY),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk       (I_CLK),
            .rstn      (I_RSTN),
            .global_en (i_global_en),
            .arm       (i_arm[c]),
            .trig      (i_trig[c]),
            .chk_en    (o_chk_en[c]),
            .on_pulse  (o_on_pulse[c]),
            .off_pulse (o_off_pulse[c]),
            .waive_cnt (o_waive_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_aw_waiver_window_gen.sv
// Directed bench for aw_waiver_window_gen with default parameters.
module tb_aw_waiver_window_gen;

    logic        clk;
    logic        rst_n;
    logic        global_en;
    logic [3:0]  arm;
    logic [3:0]  trig;
    logic [3:0]  chk_en;
    logic [3:0]  on_pulse;
    logic [3:0]  off_pulse;
    logic [31:0] waive_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] arm;
        logic [3:0] trig;
        logic       gen;
        logic [3:0] en;
        logic [3:0] on;
        logic [3:0] off;
        logic [7:0] cnt0;
    } vec_t;

    vec_t vecs[$];

    aw_waiver_window_gen #(
        .NUM_CH(4), .STABLE_CYC(4), .HOLD_CYC(8), .ARM_DLY(3), .CNT_W(8)
    ) dut (
        .I_CLK       (clk),
        .I_RSTN      (rst_n),
        .i_global_en (global_en),
        .i_arm       (arm),
        .i_trig      (trig),
        .o_chk_en    (chk_en),
        .o_on_pulse  (on_pulse),
        .o_off_pulse (off_pulse),
        .o_waive_cnt (waive_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Outputs are sampled and inputs changed at the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic add(input int c, input logic [3:0] a, input logic [3:0] t, input logic g,
                       input logic [3:0] e, input logic [3:0] on, input logic [3:0] off,
                       input logic [7:0] n);
        vec_t v;
        v.cyc = c; v.arm = a; v.trig = t; v.gen = g;
        v.en = e; v.on = on; v.off = off; v.cnt0 = n;
        vecs.push_back(v);
    endtask

    initial begin
        int idx;

        //  cyc  arm    trig   gen   en     on     off    cnt0
        add(1,   4'h0,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd0);
        add(10,  4'h1,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd0);
        add(13,  4'h1,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd0);
        add(14,  4'h1,  4'h0,  1'b1, 4'h1,  4'h1,  4'h0,  8'd0);
        add(15,  4'h1,  4'h0,  1'b1, 4'h1,  4'h0,  4'h0,  8'd0);
        add(20,  4'h1,  4'h1,  1'b1, 4'h1,  4'h0,  4'h0,  8'd0);
        add(23,  4'h1,  4'h0,  1'b1, 4'h1,  4'h0,  4'h0,  8'd0);
        add(26,  4'h1,  4'h0,  1'b1, 4'h1,  4'h0,  4'h0,  8'd0);
        add(30,  4'h1,  4'h1,  1'b1, 4'h1,  4'h0,  4'h0,  8'd0);
        add(34,  4'h1,  4'h1,  1'b1, 4'h1,  4'h0,  4'h0,  8'd0);
        add(35,  4'h1,  4'h1,  1'b1, 4'h0,  4'h0,  4'h1,  8'd1);
        add(36,  4'h1,  4'h1,  1'b1, 4'h0,  4'h0,  4'h0,  8'd1);
        add(40,  4'h3,  4'h1,  1'b1, 4'h0,  4'h0,  4'h0,  8'd1);
        add(44,  4'h3,  4'h1,  1'b1, 4'h2,  4'h2,  4'h0,  8'd1);
        add(50,  4'h3,  4'h0,  1'b1, 4'h2,  4'h0,  4'h0,  8'd1);
        add(62,  4'h3,  4'h0,  1'b1, 4'h2,  4'h0,  4'h0,  8'd1);
        add(63,  4'h3,  4'h0,  1'b1, 4'h3,  4'h1,  4'h0,  8'd1);
        add(70,  4'h3,  4'h1,  1'b1, 4'h3,  4'h0,  4'h0,  8'd1);
        add(75,  4'h3,  4'h1,  1'b1, 4'h2,  4'h0,  4'h1,  8'd2);
        add(80,  4'h3,  4'h0,  1'b1, 4'h2,  4'h0,  4'h0,  8'd2);
        add(85,  4'h3,  4'h0,  1'b1, 4'h2,  4'h0,  4'h0,  8'd2);
        add(87,  4'h3,  4'h1,  1'b1, 4'h2,  4'h0,  4'h0,  8'd2);
        add(92,  4'h3,  4'h1,  1'b1, 4'h2,  4'h0,  4'h0,  8'd2);
        add(93,  4'h3,  4'h0,  1'b1, 4'h2,  4'h0,  4'h0,  8'd2);
        add(105, 4'h3,  4'h0,  1'b1, 4'h2,  4'h0,  4'h0,  8'd2);
        add(106, 4'h3,  4'h0,  1'b1, 4'h3,  4'h1,  4'h0,  8'd2);
        add(110, 4'h3,  4'h1,  1'b1, 4'h3,  4'h0,  4'h0,  8'd2);
        add(115, 4'h3,  4'h1,  1'b1, 4'h2,  4'h0,  4'h1,  8'd3);
        add(118, 4'h3,  4'h1,  1'b0, 4'h2,  4'h0,  4'h0,  8'd3);
        add(119, 4'h3,  4'h1,  1'b0, 4'h0,  4'h0,  4'h2,  8'd3);
        add(120, 4'h3,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd3);
        add(140, 4'h3,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd3);
        add(141, 4'h2,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd3);
        add(143, 4'h3,  4'h0,  1'b0, 4'h0,  4'h0,  4'h0,  8'd3);
        add(144, 4'h3,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd3);
        add(150, 4'h3,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd3);
        add(151, 4'h2,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd3);
        add(153, 4'h3,  4'h0,  1'b1, 4'h0,  4'h0,  4'h0,  8'd3);
        add(157, 4'h3,  4'h0,  1'b1, 4'h1,  4'h1,  4'h0,  8'd3);
        add(158, 4'h3,  4'h0,  1'b1, 4'h1,  4'h0,  4'h0,  8'd3);

        rst_n     = 1'b0;
        global_en = 1'b1;
        arm       = 4'h0;
        trig      = 4'h0;
        #12;
        chk("rst_en",  {28'd0, chk_en},    32'd0);
        chk("rst_on",  {28'd0, on_pulse},  32'd0);
        chk("rst_off", {28'd0, off_pulse}, 32'd0);
        chk("rst_cnt", waive_cnt,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idx = 0;
        for (int c = 1; c <= 158; c++) begin
            step();
            if (idx < vecs.size() && vecs[idx].cyc == c) begin
                chk("vec_en",  {28'd0, chk_en},    {28'd0, vecs[idx].en});
                chk("vec_on",  {28'd0, on_pulse},  {28'd0, vecs[idx].on});
                chk("vec_off", {28'd0, off_pulse}, {28'd0, vecs[idx].off});
                chk("vec_cnt", waive_cnt,          {24'd0, vecs[idx].cnt0});
                arm       = vecs[idx].arm;
                trig      = vecs[idx].trig;
                global_en = vecs[idx].gen;
                idx++;
            end
        end
        chk("vec_all_applied", idx, vecs.size());

        // Channel 2: arm, then 300 trigger windows to saturate its counter.
        arm = 4'h7;
        for (int i = 0; i < 6; i++) step();
        chk("ch2_armed", {31'd0, chk_en[2]}, 32'd1);
        for (int w = 1; w <= 300; w++) begin
            trig = 4'h4;
            for (int i = 0; i < 6; i++) step();
            trig = 4'h0;
            for (int i = 0; i < 16; i++) step();
            if (w == 1)   chk("sat_w1",   {24'd0, waive_cnt[23:16]}, 32'd1);
            if (w == 100) chk("sat_w100", {24'd0, waive_cnt[23:16]}, 32'd100);
            if (w == 255) chk("sat_w255", {24'd0, waive_cnt[23:16]}, 32'd255);
        end
        chk("sat_w300", {24'd0, waive_cnt[23:16]}, 32'd255);
        chk("sat_ch0_untouched", {24'd0, waive_cnt[7:0]}, 32'd3);
        chk("sat_ch2_active", {31'd0, chk_en[2]}, 32'd1);

        // Drive channel 2 into HOLD, then reset asynchronously between edges.
        trig = 4'h4;
        for (int i = 0; i < 6; i++) step();
        trig = 4'h0;
        for (int i = 0; i < 8; i++) step();
        chk("hold_en", {28'd0, chk_en}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en",  {28'd0, chk_en},    32'd0);
        chk("async_rst_on",  {28'd0, on_pulse},  32'd0);
        chk("async_rst_off", {28'd0, off_pulse}, 32'd0);
        chk("async_rst_cnt", waive_cnt,          32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
